// File: rtl/damage_calc.sv
// Combat-round resolver: scans the shared unit table, sums in-range attack per side and
// applies it to the opposing front unit. Optional critical hits when DAMAGE_CRIT_EN is defined.
module damage_calc #(
  parameter int NUM_UNITS = 8,
  parameter int POS_W     = 8,
  parameter int HP_W      = 8,
  parameter int ATK_W     = 6,
  parameter int RANGE     = 2,
  parameter int MIN_DMG   = 1,
  localparam int ADDR_W   = $clog2(2*NUM_UNITS),
  localparam int SUM_W    = ATK_W + $clog2(NUM_UNITS),
  localparam int E        = 1 + POS_W + HP_W + 2*ATK_W
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              damageSCEN,
  input  logic              damageCalcACK,
  input  logic [POS_W-1:0]  frontPos,
  output logic              memRd,
  output logic [ADDR_W-1:0] memAddr,
  input  logic [E-1:0]      memRdata,
  output logic              damageCalcDone,
  output logic              tgtValidA,
  output logic              tgtValidB,
  output logic [ADDR_W-1:0] tgtIdxA,
  output logic [ADDR_W-1:0] tgtIdxB,
  output logic [SUM_W-1:0]  dmgToA,
  output logic [SUM_W-1:0]  dmgToB,
  output logic [HP_W-1:0]   newHpA,
  output logic [HP_W-1:0]   newHpB,
  output logic              killA,
`ifdef DAMAGE_CRIT_EN
  output logic              killB,
  output logic              critHit
`else
  output logic              killB
`endif
);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_SCAN  = 3'd1;
  localparam logic [2:0] S_DRAIN = 3'd2;
  localparam logic [2:0] S_CALC  = 3'd3;
  localparam logic [2:0] S_DONE  = 3'd4;

  localparam int CMP_W = (SUM_W > HP_W) ? SUM_W : HP_W;
  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(2*NUM_UNITS - 1);
  localparam logic [ADDR_W-1:0] FIRST_B   = ADDR_W'(NUM_UNITS);

  logic [2:0]        r_state;
  logic [ADDR_W-1:0] r_cnt;
  logic              r_rd_d;
  logic [E-1:0]      r_entry;
  logic              r_entry_vld;
  logic [ADDR_W-1:0] r_acc_idx;
  logic [POS_W-1:0]  r_front;

  logic [SUM_W-1:0]  r_sum_a, r_sum_b;
  logic              r_found_a, r_found_b;
  logic [ADDR_W-1:0] r_fidx_a, r_fidx_b;
  logic [POS_W-1:0]  r_fpos_a, r_fpos_b;
  logic [HP_W-1:0]   r_fhp_a, r_fhp_b;
  logic [ATK_W-1:0]  r_fdef_a, r_fdef_b;

  logic              r_valid_a, r_valid_b;
  logic [ADDR_W-1:0] r_idx_a, r_idx_b;
  logic [SUM_W-1:0]  r_dmg_a, r_dmg_b;
  logic [HP_W-1:0]   r_newhp_a, r_newhp_b;
  logic              r_kill_a, r_kill_b;

  // Entry fields, MSB->LSB {alive, pos, hp, atk, def}
  logic              w_alive;
  logic [POS_W-1:0]  w_pos;
  logic [HP_W-1:0]   w_hp;
  logic [ATK_W-1:0]  w_atk;
  logic [ATK_W-1:0]  w_def;
  logic [POS_W-1:0]  w_dist;
  logic              w_in_range;
  logic              w_is_a;

  assign w_alive    = r_entry[E-1];
  assign w_pos      = r_entry[E-2 -: POS_W];
  assign w_hp       = r_entry[2*ATK_W +: HP_W];
  assign w_atk      = r_entry[ATK_W +: ATK_W];
  assign w_def      = r_entry[0 +: ATK_W];
  assign w_dist     = (w_pos >= r_front) ? (w_pos - r_front) : (r_front - w_pos);
  assign w_in_range = (w_dist <= POS_W'(RANGE));
  assign w_is_a     = (r_acc_idx < FIRST_B);

  assign memRd          = (r_state == S_SCAN);
  assign memAddr        = (r_state == S_SCAN) ? r_cnt : '0;
  assign damageCalcDone = (r_state == S_DONE);

  function automatic logic [SUM_W-1:0] calc_dmg(input logic [SUM_W-1:0] sum,
                                                input logic [ATK_W-1:0] def);
    logic [SUM_W-1:0] d;
    d = SUM_W'(def);
    if (sum == '0)   return '0;
    else if (sum > d) return sum - d;
    else              return SUM_W'(MIN_DMG);
  endfunction

  function automatic logic [HP_W-1:0] calc_hp(input logic [SUM_W-1:0] dmg,
                                              input logic [HP_W-1:0]  hp);
    logic [CMP_W-1:0] d, h;
    d = CMP_W'(dmg);
    h = CMP_W'(hp);
    return (d >= h) ? '0 : HP_W'(h - d);
  endfunction

  logic [SUM_W-1:0] w_base_dmg_a, w_base_dmg_b;
  logic [SUM_W-1:0] w_dmg_a, w_dmg_b;
  logic [HP_W-1:0]  w_newhp_a, w_newhp_b;
  logic             w_crit;

  assign w_base_dmg_a = calc_dmg(r_sum_b, r_fdef_a);
  assign w_base_dmg_b = calc_dmg(r_sum_a, r_fdef_b);

`ifdef DAMAGE_CRIT_EN
  logic [15:0] r_lfsr;
  logic        r_crit;

  // Free-running Fibonacci LFSR, taps 16,14,13,11
  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_lfsr <= 16'hACE1;
    else       r_lfsr <= {r_lfsr[14:0], r_lfsr[15] ^ r_lfsr[13] ^ r_lfsr[12] ^ r_lfsr[10]};
  end

  function automatic logic [SUM_W-1:0] dbl_sat(input logic [SUM_W-1:0] v);
    return v[SUM_W-1] ? '1 : {v[SUM_W-2:0], 1'b0};
  endfunction

  assign w_crit  = (r_lfsr[3:0] == 4'd0);
  assign critHit = r_crit;
`else
  assign w_crit = 1'b0;
`endif

  // NOTE: always_comb assigns every output a default first so no path can infer a latch.
  always_comb begin
    w_dmg_a   = '0;
    w_dmg_b   = '0;
    w_newhp_a = '0;
    w_newhp_b = '0;
    if (r_found_a) begin
`ifdef DAMAGE_CRIT_EN
      w_dmg_a = w_crit ? dbl_sat(w_base_dmg_a) : w_base_dmg_a;
`else
      w_dmg_a = w_base_dmg_a;
`endif
      w_newhp_a = calc_hp(w_dmg_a, r_fhp_a);
    end
    if (r_found_b) begin
`ifdef DAMAGE_CRIT_EN
      w_dmg_b = w_crit ? dbl_sat(w_base_dmg_b) : w_base_dmg_b;
`else
      w_dmg_b = w_base_dmg_b;
`endif
      w_newhp_b = calc_hp(w_dmg_b, r_fhp_b);
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state     <= S_IDLE;
      r_cnt       <= '0;
      r_rd_d      <= 1'b0;
      r_entry     <= '0;
      r_entry_vld <= 1'b0;
      r_acc_idx   <= '0;
      r_front     <= '0;
    end else begin
      r_rd_d      <= memRd;
      r_entry_vld <= r_rd_d;
      if (r_rd_d) r_entry <= memRdata;
      if (r_entry_vld) r_acc_idx <= r_acc_idx + 1'b1;
      case (r_state)
        S_IDLE: if (damageSCEN) begin
          r_state   <= S_SCAN;
          r_cnt     <= '0;
          r_acc_idx <= '0;
          r_front   <= frontPos;
        end
        S_SCAN: begin
          r_cnt <= r_cnt + 1'b1;
          if (r_cnt == LAST_ADDR) r_state <= S_DRAIN;
        end
        // Two-stage read pipeline: leave once the last entry sits in r_entry
        S_DRAIN: if (!r_rd_d) r_state <= S_CALC;
        S_CALC:  r_state <= S_DONE;
        S_DONE:  if (damageCalcACK) r_state <= S_IDLE;
        default: r_state <= S_IDLE;
      endcase
    end
  end

  // Per-entry accumulation and front-unit tracking; strict compares keep the lowest index on ties
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_sum_a <= '0;  r_sum_b <= '0;
      r_found_a <= 1'b0; r_found_b <= 1'b0;
      r_fidx_a <= '0; r_fidx_b <= '0;
      r_fpos_a <= '0; r_fpos_b <= '0;
      r_fhp_a <= '0;  r_fhp_b <= '0;
      r_fdef_a <= '0; r_fdef_b <= '0;
    end else if (r_state == S_IDLE && damageSCEN) begin
      r_sum_a <= '0;  r_sum_b <= '0;
      r_found_a <= 1'b0; r_found_b <= 1'b0;
    end else if (r_entry_vld && w_alive) begin
      if (w_is_a) begin
        if (w_in_range) r_sum_a <= r_sum_a + SUM_W'(w_atk);
        if (!r_found_a || w_pos > r_fpos_a) begin
          r_found_a <= 1'b1;
          r_fidx_a  <= r_acc_idx;
          r_fpos_a  <= w_pos;
          r_fhp_a   <= w_hp;
          r_fdef_a  <= w_def;
        end
      end else begin
        if (w_in_range) r_sum_b <= r_sum_b + SUM_W'(w_atk);
        if (!r_found_b || w_pos < r_fpos_b) begin
          r_found_b <= 1'b1;
          r_fidx_b  <= r_acc_idx;
          r_fpos_b  <= w_pos;
          r_fhp_b   <= w_hp;
          r_fdef_b  <= w_def;
        end
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_valid_a <= 1'b0; r_valid_b <= 1'b0;
      r_idx_a   <= '0;   r_idx_b   <= '0;
      r_dmg_a   <= '0;   r_dmg_b   <= '0;
      r_newhp_a <= '0;   r_newhp_b <= '0;
      r_kill_a  <= 1'b0; r_kill_b  <= 1'b0;
`ifdef DAMAGE_CRIT_EN
      r_crit    <= 1'b0;
`endif
    end else if (r_state == S_CALC) begin
      r_valid_a <= r_found_a;
      r_valid_b <= r_found_b;
      r_idx_a   <= r_fidx_a;
      r_idx_b   <= r_fidx_b;
      r_dmg_a   <= w_dmg_a;
      r_dmg_b   <= w_dmg_b;
      r_newhp_a <= w_newhp_a;
      r_newhp_b <= w_newhp_b;
      r_kill_a  <= r_found_a && (w_newhp_a == '0);
      r_kill_b  <= r_found_b && (w_newhp_b == '0);
`ifdef DAMAGE_CRIT_EN
      r_crit    <= w_crit;
`endif
    end
  end

  assign tgtValidA = r_valid_a;
  assign tgtValidB = r_valid_b;
  assign tgtIdxA   = r_idx_a;
  assign tgtIdxB   = r_idx_b;
  assign dmgToA    = r_dmg_a;
  assign dmgToB    = r_dmg_b;
  assign newHpA    = r_newhp_a;
  assign newHpB    = r_newhp_b;
  assign killA     = r_kill_a;
  assign killB     = r_kill_b;

endmodule

// File: tb/tb_damage_calc.sv
// Directed self-checking bench for damage_calc with a one-cycle-latency unit-table model.
module tb_damage_calc;

  logic        clk = 1'b0;
  logic        reset;
  logic        damageSCEN, damageCalcACK;
  logic [7:0]  frontPos;
  logic        memRd;
  logic [3:0]  memAddr;
  logic [28:0] memRdata;
  logic        damageCalcDone, tgtValidA, tgtValidB, killA, killB;
  logic [3:0]  tgtIdxA, tgtIdxB;
  logic [8:0]  dmgToA, dmgToB;
  logic [7:0]  newHpA, newHpB;
`ifdef DAMAGE_CRIT_EN
  logic        critHit;
`endif

  int checks = 0;
  int errors = 0;
  int lat;
  logic [28:0] mem [16];

  always #5 clk = ~clk;

  damage_calc dut (
    .clk(clk), .reset(reset), .damageSCEN(damageSCEN), .damageCalcACK(damageCalcACK),
    .frontPos(frontPos), .memRd(memRd), .memAddr(memAddr), .memRdata(memRdata),
    .damageCalcDone(damageCalcDone), .tgtValidA(tgtValidA), .tgtValidB(tgtValidB),
    .tgtIdxA(tgtIdxA), .tgtIdxB(tgtIdxB), .dmgToA(dmgToA), .dmgToB(dmgToB),
    .newHpA(newHpA), .newHpB(newHpB), .killA(killA),
`ifdef DAMAGE_CRIT_EN
    .killB(killB), .critHit(critHit)
`else
    .killB(killB)
`endif
  );

  // Unit table: data valid exactly one cycle after the read strobe
  always @(posedge clk) if (memRd) memRdata <= mem[memAddr];

`ifdef DAMAGE_CRIT_EN
  logic [15:0] lfsr_ref;
  function automatic logic [15:0] lfsr_step(input logic [15:0] v);
    return {v[14:0], v[15] ^ v[13] ^ v[12] ^ v[10]};
  endfunction
  always @(posedge clk or posedge reset)
    if (reset) lfsr_ref <= 16'hACE1;
    else       lfsr_ref <= lfsr_step(lfsr_ref);
`endif

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [28:0] mk(input logic alive, input logic [7:0] pos, input logic [7:0] hp,
                                     input logic [5:0] atk, input logic [5:0] def);
    return {alive, pos, hp, atk, def};
  endfunction

  task automatic clear_mem();
    for (int i = 0; i < 16; i++) mem[i] = '0;
  endtask

  task automatic load_basic();
    clear_mem();
    mem[0] = mk(1'b1, 8'd49, 8'd20, 6'd5, 6'd1);
    mem[1] = mk(1'b1, 8'd40, 8'd30, 6'd7, 6'd0);
    mem[8] = mk(1'b1, 8'd51, 8'd10, 6'd4, 6'd2);
  endtask

  // Called at a negedge; returns at the negedge where done is first seen (or after the bound)
  task automatic run_round(input logic [7:0] fp, input int pulse_at, output int n);
    frontPos   = fp;
    damageSCEN = 1'b1;
    @(negedge clk);
    damageSCEN = 1'b0;
    n = 0;
    while (!damageCalcDone && n < 40) begin
      damageSCEN = (n == pulse_at);
      @(negedge clk);
      n++;
    end
    damageSCEN = 1'b0;
  endtask

  task automatic ack();
    damageCalcACK = 1'b1;
    @(negedge clk);
    damageCalcACK = 1'b0;
  endtask

  task automatic check_round(input string t, input logic va, input logic [3:0] ia, input logic [8:0] da,
                             input logic [7:0] ha, input logic ka, input logic vb, input logic [8:0] db,
                             input logic [7:0] hb, input logic kb);
    check({t, ".validA"}, tgtValidA, va);
    check({t, ".idxA"},   tgtIdxA,   ia);
    check({t, ".dmgA"},   dmgToA,    da);
    check({t, ".hpA"},    newHpA,    ha);
    check({t, ".killA"},  killA,     ka);
    check({t, ".validB"}, tgtValidB, vb);
    check({t, ".dmgB"},   dmgToB,    db);
    check({t, ".hpB"},    newHpB,    hb);
    check({t, ".killB"},  killB,     kb);
  endtask

  initial begin
    logic seen_done, seen_rd;
    reset = 1'b1; damageSCEN = 1'b0; damageCalcACK = 1'b0; frontPos = '0;
    clear_mem();

    // Reset state
    repeat (2) @(negedge clk);
    check("rst.done", damageCalcDone, 1'b0);
    check("rst.memRd", memRd, 1'b0);
    check("rst.memAddr", memAddr, 4'd0);
    check_round("rst", 1'b0, 4'd0, 9'd0, 8'd0, 1'b0, 1'b0, 9'd0, 8'd0, 1'b0);
    reset = 1'b0;
    repeat (2) @(negedge clk);

    // Basic round
    load_basic();
    run_round(8'd50, -1, lat);
    check("basic.latency", lat, 19);
    check_round("basic", 1'b1, 4'd0, 9'd3, 8'd17, 1'b0, 1'b1, 9'd3, 8'd7, 1'b0);
    check("basic.idxB", tgtIdxB, 4'd8);
    ack();
    check("basic.done_clr", damageCalcDone, 1'b0);

    // Min damage, range boundary (diff 2 in, diff 3 out), dead unit ignored, kill
    clear_mem();
    mem[3]  = mk(1'b1, 8'd100, 8'd3,  6'd1,  6'd0);
    mem[6]  = mk(1'b1, 8'd98,  8'd9,  6'd1,  6'd4);
    mem[7]  = mk(1'b0, 8'd103, 8'd9,  6'd20, 6'd0);
    mem[10] = mk(1'b1, 8'd101, 8'd50, 6'd5,  6'd6);
    mem[11] = mk(1'b1, 8'd103, 8'd1,  6'd30, 6'd0);
    mem[12] = mk(1'b1, 8'd110, 8'd1,  6'd9,  6'd0);
    run_round(8'd100, -1, lat);
    check("min.latency", lat, 19);
    check_round("min", 1'b1, 4'd3, 9'd5, 8'd0, 1'b1, 1'b1, 9'd1, 8'd49, 1'b0);
    check("min.idxB", tgtIdxB, 4'd10);
    ack();

    // All B dead, tie on max A position
    clear_mem();
    mem[0] = mk(1'b1, 8'd19, 8'd5,  6'd4,  6'd0);
    mem[2] = mk(1'b1, 8'd30, 8'd15, 6'd10, 6'd3);
    mem[5] = mk(1'b1, 8'd30, 8'd8,  6'd10, 6'd1);
    mem[9] = mk(1'b0, 8'd20, 8'd40, 6'd50, 6'd0);
    run_round(8'd20, -1, lat);
    check_round("noB", 1'b1, 4'd2, 9'd0, 8'd15, 1'b0, 1'b0, 9'd0, 8'd0, 1'b0);
    ack();

    // Handshake: start pulse mid-SCAN ignored, ACK withheld 10 cycles
    load_basic();
    run_round(8'd50, 4, lat);
    check("hs.latency", lat, 19);
    seen_done = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      seen_done &= damageCalcDone && (dmgToB == 9'd3) && (newHpA == 8'd17) && (tgtIdxB == 4'd8);
    end
    check("hs.stable", seen_done, 1'b1);
    ack();
    seen_rd = 1'b0;
    for (int i = 0; i < 5; i++) begin
      seen_rd |= memRd | damageCalcDone;
      @(negedge clk);
    end
    check("hs.no_rescan", seen_rd, 1'b0);
    check("hs.hold_idle", dmgToB, 9'd3);

    // ACK and start together in DONE: start dropped
    run_round(8'd50, -1, lat);
    check("ackstart.latency", lat, 19);
    damageCalcACK = 1'b1; damageSCEN = 1'b1;
    @(negedge clk);
    damageCalcACK = 1'b0; damageSCEN = 1'b0;
    seen_rd = 1'b0;
    for (int i = 0; i < 5; i++) begin
      seen_rd |= memRd | damageCalcDone;
      @(negedge clk);
    end
    check("ackstart.idle", seen_rd, 1'b0);
    check("ackstart.hold", newHpB, 8'd7);

    // Reset at SCAN cycle 5
    frontPos = 8'd50; damageSCEN = 1'b1;
    @(negedge clk);
    damageSCEN = 1'b0;
    repeat (5) @(negedge clk);
    check("midrst.scanning", memRd, 1'b1);
    reset = 1'b1;
    #1;
    check("midrst.memRd", memRd, 1'b0);
    check_round("midrst", 1'b0, 4'd0, 9'd0, 8'd0, 1'b0, 1'b0, 9'd0, 8'd0, 1'b0);
    @(negedge clk);
    reset = 1'b0;
    seen_done = 1'b0;
    for (int i = 0; i < 30; i++) begin
      seen_done |= damageCalcDone | memRd;
      @(negedge clk);
    end
    check("midrst.no_done", seen_done, 1'b0);

`ifdef DAMAGE_CRIT_EN
    // Align start so the LFSR low nibble is zero during CALC (19 steps ahead)
    begin
      logic [15:0] v;
      int tries = 0;
      forever begin
        v = lfsr_ref;
        for (int k = 0; k < 19; k++) v = lfsr_step(v);
        if (v[3:0] == 4'd0 || tries > 2000) break;
        @(negedge clk);
        tries++;
      end
      check("crit.aligned", (tries <= 2000), 1'b1);
    end
    load_basic();
    run_round(8'd50, -1, lat);
    check("crit.hit", critHit, 1'b1);
    check_round("crit", 1'b1, 4'd0, 9'd6, 8'd14, 1'b0, 1'b1, 9'd6, 8'd4, 1'b0);
    ack();
`else
    // Deterministic damage: the basic round repeats exactly
    load_basic();
    run_round(8'd50, -1, lat);
    check("det.dmgB", dmgToB, 9'd3);
    check("det.dmgA", dmgToA, 9'd3);
    check("det.hpB", newHpB, 8'd7);
    ack();
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
